// File: rtl/cpu_pkg.sv
// Shared types and sizes for the CPU boot path: loader FSM states and data widths.
package cpu_pkg;

    localparam int unsigned MEMORY_SIZE_DEF = 32;
    localparam int unsigned WORD_W          = 16;
    localparam int unsigned BYTE_W          = 8;

    typedef enum logic [2:0] {
        WAIT_LEN,
        DATA_HI,
        DATA_LO,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

endpackage

// File: rtl/byte_pair_packer.sv
// Joins a high byte and a following low byte into one 16-bit word, emitted
// one cycle after the low byte with a single-cycle valid strobe.
module byte_pair_packer
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        hi_d    = hi_q;
        word_d  = word_q;
        valid_d = lo_we_i;
        if (hi_we_i) begin
            hi_d = data_i;
        end
        if (lo_we_i) begin
            word_d = {hi_q, data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: takes a LEN-prefixed byte stream, writes 16-bit words to CPU memory
// and holds the CPU in reset until loaded. Define PROG_LOADER_CHECKSUM_EN for the trailing XOR byte.
module prog_loader
    import cpu_pkg::*;
#(
    parameter  int unsigned MEMORY_SIZE = MEMORY_SIZE_DEF,
    localparam int unsigned AW          = $clog2(MEMORY_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [BYTE_W-1:0] MAX_LEN = BYTE_W'(MEMORY_SIZE);

    loader_state_e state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   count_inc;
    logic [AW-1:0] addr_q, addr_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          accept;
    logic          hi_we, lo_we;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    assign in_ready  = (state_q != DONE) && (state_q != ERR);
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        addr_d  = addr_q;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // cpu_rst lags DONE by one cycle on entry but rises together with the reload
        cpu_rst_d = !((state_q == DONE) && !reload);

        case (state_q)
            WAIT_LEN: begin
                if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d = in_data;
`endif
                    if ((in_data == '0) || (in_data > MAX_LEN)) begin
                        state_d = ERR;
                    end else begin
                        len_d   = in_data[AW:0];
                        count_d = '0;
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_we   = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_we   = 1'b1;
                    addr_d  = count_q[AW-1:0];
                    count_d = count_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ in_data;
                    state_d = (count_inc == len_q) ? CSUM : DATA_HI;
`else
                    state_d = (count_inc == len_q) ? DONE : DATA_HI;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (reload) begin
                    state_d = WAIT_LEN;
                end
            end
            default: state_d = WAIT_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_LEN;
            len_q     <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            cpu_rst_q <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    byte_pair_packer u_packer (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (in_data),
        .hi_we_i     (hi_we),
        .lo_we_i     (lo_we),
        .word_o      (mem_wdata),
        .word_valid_o(mem_we)
    );

    assign mem_addr   = addr_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = (state_q == DONE);
    assign load_error = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of whole-image loads plus hand-written corner sequences;
// expected memory writes go through a scoreboard queue checked by a write monitor.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;

    prog_loader #(.MEMORY_SIZE(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        int unsigned due;
    } wr_t;

    typedef struct {
        logic [7:0]  len;
        logic [15:0] w0, w1, w2;
        bit          corrupt;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    wr_t         sb[$];
    wr_t         w;
    logic [4:0]  last_addr = '0;
    logic [15:0] img[0:31];
    vec_t        vecs[0:5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each write must match the head of the queue and land in the cycle right after its low-byte accept.
    always @(negedge clk) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                w = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.addr));
                check("wr_data", 32'(mem_wdata), 32'(w.data));
                check("wr_latency", cyc, w.due);
                last_addr = mem_addr;
            end
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            check("wr_missing", 32'(mem_we), 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
        int unsigned g;
        g = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
        in_valid = 1'b0;
        repeat (g) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        check("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] len, input bit corrupt, input int unsigned maxgap);
        logic [7:0] cs;
        cs = len;
        send_byte(len, maxgap);
        if (len != 0 && len <= 32) begin
            for (int unsigned i = 0; i < len; i++) begin
                send_byte(img[i][15:8], maxgap);
                cs ^= img[i][15:8];
                send_byte(img[i][7:0], maxgap);
                cs ^= img[i][7:0];
                sb.push_back('{5'(i), img[i], cyc});
            end
            if (CSUM_EN) send_byte(corrupt ? (cs ^ 8'h07) : cs, maxgap);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_in_ready"},   32'(in_ready),   32'd1);
        check({p, "_mem_we"},     32'(mem_we),     32'd0);
        check({p, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({p, "_mem_wdata"},  32'(mem_wdata),  32'd0);
        check({p, "_cpu_rst"},    32'(cpu_rst),    32'd1);
        check({p, "_load_done"},  32'(load_done),  32'd0);
        check({p, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    task automatic do_reload(input string p);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check({p, "_rl_in_ready"}, 32'(in_ready),   32'd1);
        check({p, "_rl_done"},     32'(load_done),  32'd0);
        check({p, "_rl_error"},    32'(load_error), 32'd0);
        check({p, "_rl_cpu_rst"},  32'(cpu_rst),    32'd1);
    endtask

    task automatic check_end(input string p, input bit exp_done, input bit exp_err);
        check({p, "_done"},        32'(load_done),  32'(exp_done));
        check({p, "_error"},       32'(load_error), 32'(exp_err));
        check({p, "_ready_low"},   32'(in_ready),   32'd0);
        check({p, "_cpu_rst_now"}, 32'(cpu_rst),    32'd1);
        @(posedge clk); #1;
        check({p, "_cpu_rst_next"}, 32'(cpu_rst),   32'(!exp_done));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h02, 16'h0805, 16'h0400, 16'h0000, 1'b0, 1'b1,      1'b0};
        vecs[1] = '{8'h02, 16'h0805, 16'h0400, 16'h0000, 1'b1, !CSUM_EN,  CSUM_EN};
        vecs[2] = '{8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,      1'b1};
        vecs[3] = '{8'h21, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0,      1'b1};
        vecs[4] = '{8'h01, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b1,      1'b0};
        vecs[5] = '{8'h03, 16'h1234, 16'hFFFF, 16'h0001, 1'b0, 1'b1,      1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int unsigned t = 0; t < 6; t++) begin
            img[0] = vecs[t].w0;
            img[1] = vecs[t].w1;
            img[2] = vecs[t].w2;
            run_load(vecs[t].len, vecs[t].corrupt, 0);
            check_end($sformatf("v%0d", t), vecs[t].exp_done, vecs[t].exp_err);
            do_reload($sformatf("v%0d", t));
        end

        // Full-depth image: last word must land at address 31.
        for (int unsigned i = 0; i < 32; i++) img[i] = 16'($urandom);
        run_load(8'h20, 1'b0, 0);
        check_end("full", 1'b1, 1'b0);
        check("full_last_addr", 32'(last_addr), 32'd31);
        do_reload("full");

        // First stream again with random valid gaps.
        img[0] = 16'h0805;
        img[1] = 16'h0400;
        run_load(8'h02, 1'b0, 3);
        check_end("gaps", 1'b1, 1'b0);
        do_reload("gaps");

        // Reset after three data bytes, then a clean load.
        send_byte(8'h02, 0);
        send_byte(8'h08, 0);
        send_byte(8'h05, 0);
        sb.push_back('{5'd0, 16'h0805, cyc});
        send_byte(8'h04, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_cpu_rst_hold", 32'(cpu_rst), 32'd1);
        run_load(8'h02, 1'b0, 0);
        check_end("after_rst", 1'b1, 1'b0);
        do_reload("after_rst");

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
